// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures completed characters with their PE/FE/BI status
// into a 16550-style FIFO (or a single holding register in non-FIFO mode) and
// presents the head entry plus RX line-status and trigger indications.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       fifo_en_in,
    input  logic       clear_in,
    input  logic [1:0] trig_lvl_in,
    input  logic [1:0] wls_in,
    input  logic       push_in,
    input  logic [7:0] data_in,
    input  logic       pe_in,
    input  logic       fe_in,
    input  logic       bi_in,
    input  logic       pop_in,
    input  logic       lsr_rd_in,
    output logic [7:0] rbr_out,
    output logic       pe_out,
    output logic       fe_out,
    output logic       bi_out,
    output logic       dr_out,
    output logic       oe_out,
    output logic       fifo_err_out,
    output logic       trig_out,
    output logic [4:0] count_out,
    output logic       full_out,
    output logic       empty_out
);

    localparam int unsigned CW = AW + 1;

    // Entry layout: {bi, fe, pe, data[7:0]}
    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] errcnt_q, errcnt_d;
    logic          oe_q, oe_d;
    logic          fifo_en_q;

    logic [CW-1:0] eff_depth;
    logic [CW-1:0] trig_level;
    logic          empty, full;
    logic [10:0]   head;
    logic          head_err;
    logic [7:0]    data_masked;
    logic [10:0]   new_entry;
    logic          new_err;
    logic          flush;
    logic          do_push, do_pop, overrun, overwrite;
    logic          err_inc, err_dec;

    // Decode status, masking, and the accepted push/pop/overrun events
    always_comb begin
        eff_depth = fifo_en_in ? CW'(DEPTH) : CW'(1);
        empty     = (count_q == '0);
        full      = (count_q == eff_depth);
        head      = mem_q[rd_ptr_q];
        head_err  = |head[10:8];

        unique case (wls_in)
            2'd0:    data_masked = {3'b000, data_in[4:0]};
            2'd1:    data_masked = {2'b00, data_in[5:0]};
            2'd2:    data_masked = {1'b0, data_in[6:0]};
            default: data_masked = data_in;
        endcase
        new_entry = {bi_in, fe_in, pe_in, data_masked};
        new_err   = bi_in | fe_in | pe_in;

        unique case (trig_lvl_in)
            2'd0:    trig_level = CW'(1);
            2'd1:    trig_level = CW'(4);
            2'd2:    trig_level = CW'(8);
            default: trig_level = CW'(14);
        endcase

        // A mode change flushes exactly like an explicit clear
        flush     = clear_in | (fifo_en_in != fifo_en_q);
        do_pop    = pop_in & ~empty & ~flush;
        // When full, a coincident pop frees the slot first
        do_push   = push_in & (~full | do_pop) & ~flush;
        overrun   = push_in & full & ~do_pop & ~flush;
        overwrite = overrun & ~fifo_en_in;

        // Overwriting the holding entry swaps one entry's error status for another
        err_inc   = (do_push | overwrite) & new_err;
        err_dec   = (do_pop | overwrite) & head_err;
    end

    // Next-state for pointers, occupancy, error-entry count and overrun flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        errcnt_d = errcnt_q;
        oe_d     = oe_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            errcnt_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) count_d = count_q + CW'(1);
            if (do_pop && !do_push) count_d = count_q - CW'(1);
            if (err_inc && !err_dec) errcnt_d = errcnt_q + CW'(1);
            if (err_dec && !err_inc) errcnt_d = errcnt_q - CW'(1);
        end

        // A new overrun outranks a coincident LSR read
        if (overrun)        oe_d = 1'b1;
        else if (lsr_rd_in) oe_d = 1'b0;
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            errcnt_q  <= '0;
            oe_q      <= 1'b0;
            fifo_en_q <= fifo_en_in;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            errcnt_q  <= errcnt_d;
            oe_q      <= oe_d;
            fifo_en_q <= fifo_en_in;
        end
    end

    // Entry storage; non-FIFO overrun replaces the head in place
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            if (do_push)        mem_q[wr_ptr_q] <= new_entry;
            else if (overwrite) mem_q[rd_ptr_q] <= new_entry;
        end
    end

    // Head view and status outputs, gated to zero when empty
    always_comb begin
        rbr_out      = empty ? 8'h00 : head[7:0];
        pe_out       = ~empty & head[8];
        fe_out       = ~empty & head[9];
        bi_out       = ~empty & head[10];
        dr_out       = ~empty;
        oe_out       = oe_q;
        fifo_err_out = fifo_en_in & (errcnt_q != '0);
        trig_out     = fifo_en_in ? (count_q >= trig_level) : ~empty;
        count_out    = count_q;
        full_out     = full;
        empty_out    = empty;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer stage that sits directly downstream of the UART RX shift/deserialiser. It captures each completed character together with its parity/framing/break status, and stores it in a 16-entry FIFO (16550 FIFO mode) or a single holding register (non-FIFO mode). It presents the head entry as RBR, plus the RX-side line-status and trigger indications, to the register/interrupt block.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of two.
AW, 4, pointer width, log2(DEPTH).

Ports:
clk_in  input  1  system clock; single clock domain, all logic on rising edge
rst_in  input  1  synchronous active-high reset
fifo_en_in  input  1  FCR[0]; 1 = FIFO mode, 0 = single holding register
clear_in  input  1  FCR[1] pulse; flush RX FIFO
trig_lvl_in  input  2  FCR[7:6]; 0/1/2/3 select trigger levels 1/4/8/14
wls_in  input  2  LCR word length; 0/1/2/3 = 5/6/7/8 data bits
push_in  input  1  one-cycle strobe from shift stage: character complete
data_in  input  8  received character, LSB first-received
pe_in  input  1  parity error for this character
fe_in  input  1  framing error for this character
bi_in  input  1  break indication for this character
pop_in  input  1  one-cycle RBR read strobe
lsr_rd_in  input  1  one-cycle LSR read strobe
rbr_out  output  8  head character; 0 when empty
pe_out  output  1  head entry parity error (LSR[2]); 0 when empty
fe_out  output  1  head entry framing error (LSR[3]); 0 when empty
bi_out  output  1  head entry break (LSR[4]); 0 when empty
dr_out  output  1  data ready (LSR[0]) = not empty
oe_out  output  1  overrun error (LSR[1]), sticky
fifo_err_out  output  1  LSR[7]; at least one stored entry has PE/FE/BI (FIFO mode only)
trig_out  output  1  RX trigger level reached
count_out  output  5  number of stored entries, 0..16
full_out  output  1  count equals effective depth
empty_out  output  1  count equals 0

Behaviour:
- Reset (rst_in=1 at clk edge): rd/wr pointers 0, count 0, error-entry counter 0, oe 0. All outputs read 0 except empty_out=1.
- Effective depth: DEPTH when fifo_en_in=1, 1 when fifo_en_in=0.
- Entry format: 11 bits {bi, fe, pe, data}.
  - Data bits above the word length are forced 0 on write.
  - wls 0 keeps data[4:0]; wls 1 keeps [5:0]; wls 2 keeps [6:0]; wls 3 keeps [7:0].
- Write: push_in with not full stores the entry at wr_ptr, increments wr_ptr (mod DEPTH) and increments count. Visible at rbr_out the next cycle if the FIFO was empty.
- Read: pop_in with not empty increments rd_ptr and decrements count. rbr_out/pe/fe/bi are a combinational view of mem[rd_ptr], gated to 0 when empty.
- Simultaneous push and pop:
  - Not empty, not full: both performed, count unchanged.
  - Full: pop then push, both accepted, no overrun.
  - Empty: push accepted, pop ignored.
- Pop on empty: ignored, no state change.
- Overrun (push_in while full and no pop):
  - FIFO mode: new character discarded, FIFO contents unchanged, oe set.
  - Non-FIFO mode: holding entry overwritten with new character, oe set.
- oe is cleared by lsr_rd_in. If set and clear happen in the same cycle, set wins (oe=1).
- Error counter: +1 on each accepted write whose pe|fe|bi=1, -1 on each accepted pop whose head has pe|fe|bi=1; both in the same cycle leaves it unchanged.
  - fifo_err_out = fifo_en_in & (errcnt != 0).
- Trigger:
  - FIFO mode: trig_out = count_out >= level (1, 4, 8, 14).
  - Non-FIFO mode: trig_out = dr_out.
- Flush: clear_in=1, or any change of fifo_en_in (registered copy compared each cycle), resets pointers, count and error counter on that edge.
  - Any push/pop in the same cycle is discarded.
  - oe is not affected.
- Reset has priority over flush; flush has priority over push/pop.
- Reset asserted mid-operation discards all contents on the next edge.

Test Plan:
- Reset, fifo_en=1, wls=3; push 0xA5 -> next cycle dr_out=1, rbr_out=0xA5, count_out=1; pop -> empty_out=1, rbr_out=0.
- wls=0, push 0xFF -> rbr_out=0x1F; wls=2, push 0xFF -> second entry reads 0x7F.
- FIFO mode, push 16 chars 0x00..0x0F -> full_out=1; push 0x55 -> oe_out=1, head still 0x00; pop all 16 -> sequence 0x00..0x0F; lsr_rd -> oe_out=0.
- Full, simultaneous push 0x77 and pop -> no oe, count stays 16, last entry read is 0x77. Separately, lsr_rd coincident with an overrun -> oe_out stays 1.
- trig_lvl=2: push 7 chars -> trig_out=0; 8th -> trig_out=1. Push entries with fe on #2 -> fifo_err_out=1 until entry #2 is popped; clear_in -> count 0, fifo_err_out=0, oe unchanged.
- fifo_en=0: push 0x11 then 0x22 with no pop -> rbr_out=0x22, oe_out=1, count_out=1, trig_out=1. Toggle fifo_en to 1 -> contents flushed, empty_out=1.
